// File: rtl/fm_phase_scheduler.sv
// FM modulator sequencer: buffers audio samples and drives the DDS enable strobe and
// phase increment (carrier plus scaled deviation), with underrun tracking.
module fm_phase_scheduler #(
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_DIV   = 64,
    parameter int NBITS_SAMPLE = 18,
    parameter int GAIN_SHIFT   = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PRIME_LEVEL  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic [31:0]             carrier_inc,
    input  logic [15:0]             dev_gain,
    input  logic [NBITS_SAMPLE-1:0] in_sample,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    enableclk,
    output logic [31:0]             phaseinc,
    output logic                    phaseinc_valid,
    output logic                    underrun,
    input  logic                    underrun_clr,
    output logic [7:0]              underrun_count,
    output logic [1:0]              state
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = NBITS_SAMPLE + 16;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PRIME_CNT = (AW+1)'(PRIME_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [TW-1:0]            tick_q, tick_d;
    logic                     enableclk_q, enableclk_d;
    logic [NBITS_SAMPLE-1:0]  mem_q [FIFO_DEPTH];
    logic [NBITS_SAMPLE-1:0]  mem_d [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]              count_q, count_d;
    logic                     in_ready_q, in_ready_d;
    logic signed [PW-1:0]     prod_q, prod_d;
    logic                     p1_valid_q, p1_valid_d;
    logic [31:0]              phaseinc_q, phaseinc_d;
    logic                     valid_q, valid_d;
    logic                     underrun_q, underrun_d;
    logic [7:0]               ur_count_q, ur_count_d;

    logic                     counting, sample_tick, take, pop, push, ur_event;
    logic signed [PW-1:0]     head_x, gain_x, scaled;
    logic signed [31:0]       scaled32;

    always_comb begin
        state_d = state_q;
        if (!run) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: if (count_q >= PRIME_CNT) state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Divider and tick counters only advance while staying out of IDLE, so the
    // first PRIME cycle always starts from zero.
    always_comb begin
        counting    = (state_q != ST_IDLE) && (state_d != ST_IDLE);
        sample_tick = enableclk_q && (tick_q == TICK_LAST);
        cnt_d       = '0;
        tick_d      = '0;
        if (counting) begin
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            tick_d = tick_q;
            if (enableclk_q) tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        end
        enableclk_d = (state_d != ST_IDLE) && (cnt_d == CNT_LAST);
    end

    // Handshake: a sample is transferred on a rising edge where in_valid & in_ready;
    // in_ready reflects registered occupancy only, so a same-cycle pop is not credited.
    always_comb begin
        take     = sample_tick && (state_q == ST_RUN) && (state_d == ST_RUN);
        pop      = take && (count_q != '0);
        ur_event = take && (count_q == '0);
        push     = in_valid && in_ready_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (state_d == ST_IDLE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_sample;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        in_ready_d = (state_d != ST_IDLE) && (count_d != FULL_CNT);
    end

    always_comb begin
        head_x     = PW'($signed(mem_q[rd_ptr_q]));
        gain_x     = PW'($signed(dev_gain));
        p1_valid_d = take;
        prod_d     = prod_q;
        if (take) prod_d = pop ? head_x * gain_x : '0;

        scaled     = prod_q >>> GAIN_SHIFT;
        scaled32   = 32'(scaled);
        phaseinc_d = phaseinc_q;
        valid_d    = 1'b0;
        if (state_d != ST_IDLE) begin
            if (state_q == ST_PRIME) phaseinc_d = carrier_inc;
            if (p1_valid_q) begin
                phaseinc_d = carrier_inc + scaled32;
                valid_d    = 1'b1;
            end
        end

        underrun_d = underrun_q;
        ur_count_d = ur_count_q;
        if (underrun_clr) begin
            underrun_d = 1'b0;
            ur_count_d = '0;
        end else if (ur_event) begin
            underrun_d = 1'b1;
            if (ur_count_q != 8'hFF) ur_count_d = ur_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tick_q      <= '0;
            enableclk_q <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            prod_q      <= '0;
            p1_valid_q  <= 1'b0;
            phaseinc_q  <= '0;
            valid_q     <= 1'b0;
            underrun_q  <= 1'b0;
            ur_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            enableclk_q <= enableclk_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            prod_q      <= prod_d;
            p1_valid_q  <= p1_valid_d;
            phaseinc_q  <= phaseinc_d;
            valid_q     <= valid_d;
            underrun_q  <= underrun_d;
            ur_count_q  <= ur_count_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign enableclk      = enableclk_q;
    assign phaseinc       = phaseinc_q;
    assign phaseinc_valid = valid_q;
    assign underrun       = underrun_q;
    assign underrun_count = ur_count_q;
    assign state          = state_q;

endmodule

// File: tb/tb_fm_phase_scheduler.sv
// Bench for fm_phase_scheduler: directed scenarios plus random traffic, every cycle
// compared against a queue/arithmetic reference model.
module tb_fm_phase_scheduler;
    localparam int CD = 4;
    localparam int SD = 4;
    localparam int NS = 18;
    localparam int GS = 8;
    localparam int DEPTH = 4;
    localparam int PL = 2;

    logic          clock = 1'b0;
    logic          reset, run, in_valid, underrun_clr;
    logic [31:0]   carrier_inc;
    logic [15:0]   dev_gain;
    logic [NS-1:0] in_sample;
    logic          in_ready, enableclk, phaseinc_valid, underrun;
    logic [31:0]   phaseinc;
    logic [7:0]    underrun_count;
    logic [1:0]    state;

    always #5 clock = ~clock;

    fm_phase_scheduler #(
        .CLK_DIV(CD), .SAMPLE_DIV(SD), .NBITS_SAMPLE(NS), .GAIN_SHIFT(GS),
        .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PL)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .carrier_inc(carrier_inc),
        .dev_gain(dev_gain), .in_sample(in_sample), .in_valid(in_valid),
        .in_ready(in_ready), .enableclk(enableclk), .phaseinc(phaseinc),
        .phaseinc_valid(phaseinc_valid), .underrun(underrun), .underrun_clr(underrun_clr),
        .underrun_count(underrun_count), .state(state)
    );

    int chk_count = 0;
    int fail_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: k = cycles since PRIME entry; strobes follow from k by division.
    typedef struct { int s; int g; int due; } pend_t;
    int          m_state, m_k, edge_n, ur_events, m_ur_count;
    int          m_fifo[$];
    pend_t       m_pend[$];
    logic [31:0] m_phaseinc;
    logic        m_valid, m_underrun, m_accept;
    logic [31:0] exp_q[$];

    function automatic bit m_enable();
        return (m_state != 0) && ((m_k % CD) == CD - 1);
    endfunction

    function automatic bit m_tick();
        return m_enable() && (((m_k / CD) % SD) == SD - 1);
    endfunction

    function automatic bit m_ready();
        return (m_state != 0) && (m_fifo.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_state = 0; m_k = 0; m_fifo.delete(); m_pend.delete();
        m_phaseinc = '0; m_valid = 1'b0; m_underrun = 1'b0; m_ur_count = 0; m_accept = 1'b0;
    endtask

    task automatic model_step();
        bit tick, rdy, ev;
        int st, sz;
        pend_t p;
        longint prod;
        edge_n++;
        if (!reset) begin
            model_reset();
            return;
        end
        st = m_state; tick = m_tick(); rdy = m_ready(); sz = m_fifo.size();
        m_valid = 1'b0; ev = 1'b0; m_accept = 1'b0;
        if (!run) begin
            m_state = 0; m_k = 0; m_fifo.delete(); m_pend.delete();
        end else begin
            if (m_pend.size() > 0 && m_pend[0].due == edge_n) begin
                p = m_pend.pop_front();
                prod = (longint'(p.s) * longint'(p.g)) >>> GS;
                m_phaseinc = carrier_inc + prod[31:0];
                m_valid = 1'b1;
            end
            if (st == 1) m_phaseinc = carrier_inc;
            if (st == 2 && tick) begin
                p.due = edge_n + 1;
                p.g = int'($signed(dev_gain));
                if (sz > 0) p.s = m_fifo.pop_front();
                else begin
                    p.s = 0; ev = 1'b1; ur_events++;
                end
                m_pend.push_back(p);
            end
            if (in_valid && rdy) begin
                m_fifo.push_back(int'($signed(in_sample)));
                m_accept = 1'b1;
            end
            if (st == 0) begin
                m_state = 1; m_k = 0;
            end else begin
                m_k++;
                if (st == 1 && sz >= PL) m_state = 2;
            end
        end
        if (underrun_clr) begin
            m_underrun = 1'b0; m_ur_count = 0;
        end else if (ev) begin
            m_underrun = 1'b1;
            if (m_ur_count < 255) m_ur_count++;
        end
    endtask

    task automatic check_all();
        check("state", 32'(state), 32'(m_state));
        check("enableclk", 32'(enableclk), 32'(m_enable()));
        check("in_ready", 32'(in_ready), 32'(m_ready()));
        check("phaseinc", phaseinc, m_phaseinc);
        check("phaseinc_valid", 32'(phaseinc_valid), 32'(m_valid));
        check("underrun", 32'(underrun), 32'(m_underrun));
        check("underrun_count", 32'(underrun_count), 32'(m_ur_count));
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
        if (m_valid && exp_q.size() > 0) check("directed_phaseinc", phaseinc, exp_q.pop_front());
    endtask

    task automatic push(input int s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sample = NS'(s);
        do begin
            step();
            n++;
        end while (!m_accept && n < 50);
        check("push_accept", 32'(m_accept), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            step();
            n++;
        end
        check("directed_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        fail_count++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", chk_count, fail_count);
        $finish;
    end

    initial begin
        int n;
        reset = 1'b0; run = 1'b1; in_valid = 1'b1; in_sample = '0; underrun_clr = 1'b0;
        carrier_inc = 32'h0100_0000; dev_gain = 16'h0100;
        edge_n = 0; ur_events = 0;
        model_reset();
        #1 check_all();
        repeat (3) step();
        reset = 1'b1; run = 1'b0; in_valid = 1'b0;
        repeat (2) step();

        // modulation: +100 / -100 with gain 0x100, shift 8
        run = 1'b1;
        exp_q = '{32'h0100_0064, 32'h00FF_FF9C};
        push(100);
        push(-100);
        drain();

        // carrier wraps modulo 2^32
        run = 1'b0; step(); run = 1'b1;
        carrier_inc = 32'hFFFF_FFF0;
        exp_q = '{32'h0000_0010, 32'h0000_0010};
        push(32'h20);
        push(32'h20);
        drain();

        // underruns saturate at 255
        carrier_inc = 32'h0123_4567;
        n = 0;
        while (ur_events < 300 && n < 8000) begin
            step();
            n++;
        end
        check("ur_count_sat", 32'(underrun_count), 32'd255);
        check("ur_flag", 32'(underrun), 32'd1);

        // clear collides with an underrun event
        n = 0;
        while (!(m_tick() && m_state == 2) && n < 100) begin
            step();
            n++;
        end
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("ur_clr_count", 32'(underrun_count), 32'd0);
        check("ur_clr_flag", 32'(underrun), 32'd0);

        // backpressure, stop mid-pipeline, re-prime
        carrier_inc = 32'h0100_0000;
        in_valid = 1'b1;
        n = 0;
        while (m_ready() && n < 20) begin
            in_sample = NS'($urandom);
            step();
            n++;
        end
        check("in_ready_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        n = 0;
        while (m_pend.size() == 0 && n < 100) begin
            step();
            n++;
        end
        run = 1'b0;
        step();
        check("stop_state", 32'(state), 32'd0);
        check("stop_no_valid", 32'(phaseinc_valid), 32'd0);
        check("stop_in_ready", 32'(in_ready), 32'd0);
        run = 1'b1;
        push(int'($urandom_range(0, 1000)));
        repeat (40) step();
        check("prime_hold", 32'(state), 32'd1);
        push(int'($urandom_range(0, 1000)));
        step();
        check("prime_exit", 32'(state), 32'd2);

        // random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sample = NS'($urandom);
            dev_gain = 16'($urandom);
            if ($urandom_range(0, 99) == 0) carrier_inc = $urandom;
            run = ($urandom_range(0, 299) != 0);
            underrun_clr = ($urandom_range(0, 199) == 0);
            if (i == 1500) begin
                #2 reset = 1'b0;
                #1 model_reset();
                check_all();
                step();
                reset = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", chk_count, fail_count);
        $finish;
    end
endmodule
